gearbox_tx_flex: RTL and testbench
==================================

Name: gearbox_tx_flex

Overview:
Parametrised Interlaken transmit gearbox. It converts 67-bit framed words (64b/67b) into a continuous OUT_WIDTH-bit stream for the GT transmit datapath, and back-pressures the framing layer with a valid/ready handshake. Sits between the TX framing/scrambler logic and the transceiver TXDATA port, all in the USER_CLK domain.

Parameters:
IN_WIDTH, 67, input word width (Interlaken 64b/67b word).
OUT_WIDTH, 20, output width per cycle; legal range 8..IN_WIDTH.
BUF_WIDTH, IN_WIDTH+OUT_WIDTH, accumulator depth in bits; must be >= IN_WIDTH+OUT_WIDTH-1.
MSB_FIRST, 1, 1: word bit IN_WIDTH-1 goes on the wire first; 0: bit 0 goes first.

Ports:
USER_CLK  in  1  single clock; all logic on the rising edge.
RESET  in  1  synchronous, active-high reset.
DATA_IN  in  IN_WIDTH  framed word from the TX framing layer.
DATA_IN_VALID  in  1  DATA_IN is valid.
DATA_IN_READY  out  1  gearbox accepts DATA_IN this cycle.
DATA_OUT  out  OUT_WIDTH  registered output slice; the first-on-wire bit is at DATA_OUT[OUT_WIDTH-1] when MSB_FIRST=1, at DATA_OUT[0] when MSB_FIRST=0.
DATA_OUT_VALID  out  1  DATA_OUT holds a fresh slice this cycle.
UNDERRUN  out  1  one-cycle pulse when no slice could be emitted after the stream has started.
FILL_LEVEL  out  clog2(BUF_WIDTH+1)  current count of buffered bits.

Behaviour:
- Reset values: DATA_OUT=0, DATA_OUT_VALID=0, UNDERRUN=0, FILL_LEVEL=0, buffer=0, started flag=0. Reset wins over every other event in the same cycle, and buffered bits are discarded.
- Per-cycle terms:
  - emit = (FILL >= OUT_WIDTH).
  - DATA_IN_READY = (FILL - (emit ? OUT_WIDTH : 0) + IN_WIDTH <= BUF_WIDTH) and not RESET. It is driven combinationally from registers and RESET only, never from DATA_IN_VALID.
  - accept = DATA_IN_VALID and DATA_IN_READY.
- Next fill: FILL_next = FILL - (emit ? OUT_WIDTH : 0) + (accept ? IN_WIDTH : 0). Emit and accept in the same cycle are legal.
- Bit ordering: the buffer is a FIFO of bits in wire order. The oldest OUT_WIDTH bits are removed on emit, and the remaining bits shift toward the head. An accepted word is appended directly after the remaining bits, so no bit is dropped, duplicated or reordered.
- Output register:
  - On emit, DATA_OUT is loaded with the head slice and DATA_OUT_VALID is set to 1.
  - Otherwise DATA_OUT holds its previous value and DATA_OUT_VALID is set to 0.
- Latency: a word accepted at edge k into an empty buffer appears as its first slice on DATA_OUT after edge k+1.
- started: set on the first accept after reset. UNDERRUN = started and not emit, registered and aligned with DATA_OUT_VALID=0.
- Throughput: with DATA_IN_VALID held high, DATA_IN_READY averages OUT_WIDTH/IN_WIDTH and DATA_OUT_VALID stays continuously 1 after the first slice.
- Boundaries:
  - FILL = BUF_WIDTH is reachable; READY is then 0 unless emit frees enough space.
  - FILL never exceeds BUF_WIDTH and never goes negative.
  - A residual of fewer than OUT_WIDTH bits is held indefinitely until more data arrives.

Decomposition:
- Shared package gearbox_pkg holds:
  - constant IL_WORD_WIDTH=67;
  - a clog2 function;
  - a parameter-legality check used in an elaboration-time assertion (OUT_WIDTH <= IN_WIDTH, BUF_WIDTH >= IN_WIDTH+OUT_WIDTH-1).
- Single module, no sub-module. The bit-order selection is a generate block at the input and output boundaries.

Test Plan:
1. Reset: RESET high for 3 cycles -> DATA_OUT=0, DATA_OUT_VALID=0, UNDERRUN=0, FILL_LEVEL=0, DATA_IN_READY=1 after release.
2. Single word, defaults: DATA_IN=67'h4_0123456789ABCDEF accepted once -> next cycle DATA_OUT=20'h80246 with VALID=1, then 2 further valid slices, then FILL_LEVEL=7, VALID=0 and UNDERRUN pulses each idle cycle.
3. Saturated stream: VALID high, 200 sequential random words -> serialized output equals the reference bitstream. Exactly 67 slices per 20 accepts; VALID continuous after the first slice; no UNDERRUN.
4. Random back-pressure: VALID toggled at 50 % -> bitstream integrity preserved; UNDERRUN is asserted only when FILL_LEVEL<20; FILL_LEVEL never exceeds 87.
5. Reset mid-stream: RESET asserted when FILL_LEVEL=47 -> FILL_LEVEL=0 and DATA_OUT=0 on the next cycle. The first word after reset emerges from bit 0 with no stale bits.
6. Alternate parameters: MSB_FIRST=0, OUT_WIDTH=32, word 67'h0_00000000_FFFFFFFF -> first slice 32'hFFFFFFFF, second slice 32'h00000000, FILL_LEVEL=3.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared definitions for the Interlaken gearbox family.
//   IL_WORD_WIDTH     : width of a framed 64b/67b word
//   clog2()           : ceiling log2, usable in parameter expressions
//   gearbox_params_ok : elaboration-time legality check of width parameters
`timescale 1ns/1ps
package gearbox_pkg;

    localparam int IL_WORD_WIDTH = 67;

    // Ceiling log2; returns at least 1 so a width derived from it is never zero.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // The accumulator must hold a full word on top of the largest residual
    // that can remain after an emit (OUT_WIDTH-1 bits).
    function automatic bit gearbox_params_ok(input int in_w, input int out_w, input int buf_w);
        return (out_w >= 8) && (out_w <= in_w) && (buf_w >= in_w + out_w - 1);
    endfunction

endpackage

// File: rtl/gearbox_tx_flex.sv
// Interlaken transmit gearbox: serialises IN_WIDTH-bit framed words into a
// continuous OUT_WIDTH-bit stream, with valid/ready back-pressure upstream.
// Ports:
//   USER_CLK       : single clock, rising edge
//   RESET          : synchronous active-high reset
//   DATA_IN        : framed word from the framing layer
//   DATA_IN_VALID  : DATA_IN is valid
//   DATA_IN_READY  : word is accepted this cycle (combinational from state and RESET)
//   DATA_OUT       : registered output slice
//   DATA_OUT_VALID : DATA_OUT holds a fresh slice
//   UNDERRUN       : one-cycle pulse when no slice could be emitted after start
//   FILL_LEVEL     : number of buffered bits
`timescale 1ns/1ps
module gearbox_tx_flex
    import gearbox_pkg::*;
#(
    parameter int IN_WIDTH  = IL_WORD_WIDTH,
    parameter int OUT_WIDTH = 20,
    parameter int BUF_WIDTH = IN_WIDTH + OUT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    localparam int FILL_W   = clog2(BUF_WIDTH + 1)
) (
    input  logic                 USER_CLK,
    input  logic                 RESET,
    input  logic [IN_WIDTH-1:0]  DATA_IN,
    input  logic                 DATA_IN_VALID,
    output logic                 DATA_IN_READY,
    output logic [OUT_WIDTH-1:0] DATA_OUT,
    output logic                 DATA_OUT_VALID,
    output logic                 UNDERRUN,
    output logic [FILL_W-1:0]    FILL_LEVEL
);

    localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] IN_W_F   = FILL_W'(IN_WIDTH);
    // Largest post-emit fill at which a whole word still fits.
    localparam logic [FILL_W-1:0] ROOM_MAX = FILL_W'(BUF_WIDTH - IN_WIDTH);

    if (!gearbox_params_ok(IN_WIDTH, OUT_WIDTH, BUF_WIDTH)) begin : g_bad_params
        $error("gearbox_tx_flex: illegal IN_WIDTH/OUT_WIDTH/BUF_WIDTH combination");
    end

    // The buffer is kept in wire order: bit 0 is the oldest bit (next on the
    // wire). Bits at or above the fill level are always zero, so an accepted
    // word can simply be OR-ed in at the fill position.
    logic [BUF_WIDTH-1:0] buf_q, buf_d, buf_rem;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_rem;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 underrun_q, underrun_d;
    logic                 started_q, started_d;
    logic                 emit, ready, accept;

    logic [IN_WIDTH-1:0]  word_ord;    // DATA_IN in wire order (index 0 first)
    logic [BUF_WIDTH-1:0] word_ext;
    logic [OUT_WIDTH-1:0] slice_wire;  // head slice mapped to DATA_OUT bit order

    // Input boundary: map the word into wire order.
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_in_order
        if (MSB_FIRST) begin : g_msb
            assign word_ord[gi] = DATA_IN[IN_WIDTH-1-gi];
        end else begin : g_lsb
            assign word_ord[gi] = DATA_IN[gi];
        end
    end

    // Output boundary: first-on-wire bit lands at the MSB or LSB of DATA_OUT.
    for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_out_order
        if (MSB_FIRST) begin : g_msb
            assign slice_wire[OUT_WIDTH-1-gi] = buf_q[gi];
        end else begin : g_lsb
            assign slice_wire[gi] = buf_q[gi];
        end
    end

    assign word_ext = BUF_WIDTH'(word_ord);

    always_comb begin
        emit       = (fill_q >= OUT_W_F);
        fill_rem   = emit ? (fill_q - OUT_W_F) : fill_q;
        buf_rem    = emit ? (buf_q >> OUT_WIDTH) : buf_q;
        ready      = !RESET && (fill_rem <= ROOM_MAX);
        accept     = DATA_IN_VALID && ready;

        buf_d      = buf_rem;
        fill_d     = fill_rem;
        if (accept) begin
            buf_d  = buf_rem | (word_ext << fill_rem);
            fill_d = fill_rem + IN_W_F;
        end

        data_out_d = data_out_q;
        if (emit) begin
            data_out_d = slice_wire;
        end
        valid_d    = emit;
        underrun_d = started_q && !emit;
        started_d  = started_q || accept;
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            buf_q      <= '0;
            fill_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            started_q  <= started_d;
        end
    end

    assign DATA_IN_READY  = ready;
    assign DATA_OUT       = data_out_q;
    assign DATA_OUT_VALID = valid_q;
    assign UNDERRUN       = underrun_q;
    assign FILL_LEVEL     = fill_q;

endmodule

// File: tb/tb_gearbox_tx_flex.sv
`timescale 1ns/1ps
module tb_gearbox_tx_flex;

    localparam int IW  = 67;
    localparam int OW  = 20;
    localparam int BW  = 87;
    localparam int FW  = 7;
    localparam int OWB = 32;
    localparam int BWB = 99;
    localparam int FWB = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters, MSB first
    logic          a_rst = 1'b1, a_vld = 1'b0;
    logic [IW-1:0] a_din = '0;
    logic          a_ready, a_valid_o, a_under;
    logic [OW-1:0] a_dout;
    logic [FW-1:0] a_fill;

    gearbox_tx_flex #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .BUF_WIDTH(BW), .MSB_FIRST(1'b1)) u_a (
        .USER_CLK(clk), .RESET(a_rst), .DATA_IN(a_din), .DATA_IN_VALID(a_vld),
        .DATA_IN_READY(a_ready), .DATA_OUT(a_dout), .DATA_OUT_VALID(a_valid_o),
        .UNDERRUN(a_under), .FILL_LEVEL(a_fill));

    // DUT B: LSB first, 32-bit output
    logic           b_rst = 1'b1, b_vld = 1'b0;
    logic [IW-1:0]  b_din = '0;
    logic           b_ready, b_valid_o, b_under;
    logic [OWB-1:0] b_dout;
    logic [FWB-1:0] b_fill;

    gearbox_tx_flex #(.IN_WIDTH(IW), .OUT_WIDTH(OWB), .BUF_WIDTH(BWB), .MSB_FIRST(1'b0)) u_b (
        .USER_CLK(clk), .RESET(b_rst), .DATA_IN(b_din), .DATA_IN_VALID(b_vld),
        .DATA_IN_READY(b_ready), .DATA_OUT(b_dout), .DATA_OUT_VALID(b_valid_o),
        .UNDERRUN(b_under), .FILL_LEVEL(b_fill));

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of bits in wire order.
    bit            mq[$];
    bit            m_started = 1'b0;
    logic [OW-1:0] exp_out = '0;
    bit            exp_valid = 1'b0, exp_under = 1'b0, exp_ready = 1'b0, m_accept = 1'b0;
    int            exp_fill = 0;
    logic          obs_ready;

    function automatic logic [IW-1:0] rand_word();
        logic [2:0] top;
        top = 3'($urandom_range(0, 7));
        return {top, $urandom, $urandom};
    endfunction

    // One clock of DUT A plus the model. Inputs are applied at the falling
    // edge, READY is sampled before the rising edge and outputs 1 ns after it.
    task automatic cycle_a(input bit rst, input bit vld, input logic [IW-1:0] din);
        int fill_m;
        bit emit_m;
        @(negedge clk);
        a_rst = rst; a_vld = vld; a_din = din;
        #1;
        obs_ready = a_ready;
        fill_m    = mq.size();
        emit_m    = (fill_m >= OW);
        exp_ready = !rst && ((fill_m - (emit_m ? OW : 0) + IW) <= BW);
        m_accept  = 1'b0;
        if (rst) begin
            mq.delete();
            m_started = 1'b0;
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_under = 1'b0;
        end else begin
            if (emit_m) begin
                for (int j = 0; j < OW; j++) exp_out[OW-1-j] = mq.pop_front();
            end
            exp_valid = emit_m;
            exp_under = m_started && !emit_m;
            if (vld && exp_ready) begin
                for (int i = IW - 1; i >= 0; i--) mq.push_back(din[i]);
                m_started = 1'b1;
                m_accept  = 1'b1;
            end
        end
        exp_fill = mq.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cycle_a(1'b1, 1'b0, '0);
            total++; if (a_dout !== exp_out) begin bad++; $display("FAIL reset_dout: got %h want %h", a_dout, exp_out); end
            total++; if (a_valid_o !== exp_valid) begin bad++; $display("FAIL reset_valid: got %b want %b", a_valid_o, exp_valid); end
            total++; if (a_under !== exp_under) begin bad++; $display("FAIL reset_underrun: got %b want %b", a_under, exp_under); end
            total++; if (a_fill !== FW'(exp_fill)) begin bad++; $display("FAIL reset_fill: got %0d want %0d", a_fill, exp_fill); end
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL reset_ready_in_reset: got %b want %b", obs_ready, exp_ready); end
        end
        cycle_a(1'b0, 1'b0, '0);
        total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_release: got %b want 1", obs_ready); end
        total++; if (a_fill !== 7'd0) begin bad++; $display("FAIL reset_fill_release: got %0d want 0", a_fill); end
        $display("test_reset: done");
    endtask

    task automatic test_single_word();
        cycle_a(1'b0, 1'b1, 67'h4_0123456789ABCDEF);
        total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL single_ready: got %b want %b", obs_ready, exp_ready); end
        for (int c = 0; c < 6; c++) begin
            cycle_a(1'b0, 1'b0, '0);
            if (c == 0) begin
                total++; if (a_dout !== 20'h80246) begin bad++; $display("FAIL single_first_slice: got %h want 80246", a_dout); end
            end
            total++; if (a_dout !== exp_out) begin bad++; $display("FAIL single_dout c=%0d: got %h want %h", c, a_dout, exp_out); end
            total++; if (a_valid_o !== exp_valid) begin bad++; $display("FAIL single_valid c=%0d: got %b want %b", c, a_valid_o, exp_valid); end
            total++; if (a_under !== exp_under) begin bad++; $display("FAIL single_underrun c=%0d: got %b want %b", c, a_under, exp_under); end
            total++; if (a_fill !== FW'(exp_fill)) begin bad++; $display("FAIL single_fill c=%0d: got %0d want %0d", c, a_fill, exp_fill); end
        end
        total++; if (a_fill !== 7'd7) begin bad++; $display("FAIL single_residual: got %0d want 7", a_fill); end
        total++; if (a_under !== 1'b1) begin bad++; $display("FAIL single_idle_underrun: got %b want 1", a_under); end
        $display("test_single_word: done");
    endtask

    task automatic test_saturated();
        int n_acc = 0, n_slices = 0, cycles = 0;
        bit seen_first = 1'b0, gap = 1'b0, any_under = 1'b0, data_bad = 1'b0;
        logic [IW-1:0] cur;
        cycle_a(1'b1, 1'b0, '0);
        cycle_a(1'b1, 1'b0, '0);
        cur = rand_word();
        while (n_acc < 200 && cycles < 2000) begin
            cycle_a(1'b0, 1'b1, cur);
            cycles++;
            if (m_accept) begin n_acc++; cur = rand_word(); end
            if (a_valid_o === 1'b1) begin n_slices++; seen_first = 1'b1; end
            else if (seen_first) gap = 1'b1;
            if (a_under !== 1'b0) any_under = 1'b1;
            if (a_dout !== exp_out || a_valid_o !== exp_valid || a_fill !== FW'(exp_fill) || obs_ready !== exp_ready)
                data_bad = 1'b1;
        end
        total++; if (n_acc != 200) begin bad++; $display("FAIL sat_budget: accepted %0d want 200", n_acc); end
        total++; if (data_bad) begin bad++; $display("FAIL sat_stream: got mismatching output want reference bitstream"); end
        total++; if (gap) begin bad++; $display("FAIL sat_continuous: got valid gap want none"); end
        total++; if (any_under) begin bad++; $display("FAIL sat_underrun: got pulse want none"); end
        for (int c = 0; c < 6; c++) begin
            cycle_a(1'b0, 1'b0, '0);
            if (a_valid_o === 1'b1) n_slices++;
            total++; if (a_dout !== exp_out) begin bad++; $display("FAIL sat_drain_dout: got %h want %h", a_dout, exp_out); end
        end
        total++; if (n_slices != 670) begin bad++; $display("FAIL sat_slice_count: got %0d want 670", n_slices); end
        total++; if (a_fill !== 7'd0) begin bad++; $display("FAIL sat_drain_fill: got %0d want 0", a_fill); end
        $display("test_saturated: accepts=%0d slices=%0d", n_acc, n_slices);
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] cur;
        int prev_fill = 0, errs = 0;
        cur = rand_word();
        for (int c = 0; c < 400; c++) begin
            cycle_a(1'b0, 1'($urandom_range(0, 1)), cur);
            if (m_accept) cur = rand_word();
            total++;
            if (a_dout !== exp_out || a_valid_o !== exp_valid || a_under !== exp_under ||
                a_fill !== FW'(exp_fill) || obs_ready !== exp_ready) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL bp_cycle %0d: got dout=%h v=%b u=%b fill=%0d rdy=%b want %h %b %b %0d %b",
                                       c, a_dout, a_valid_o, a_under, a_fill, obs_ready,
                                       exp_out, exp_valid, exp_under, exp_fill, exp_ready);
            end
            total++; if (a_under === 1'b1 && prev_fill >= OW) begin bad++; $display("FAIL bp_underrun_level: got pulse with prior fill %0d want fill<20", prev_fill); end
            total++; if (a_fill > 7'd87) begin bad++; $display("FAIL bp_fill_max: got %0d want <=87", a_fill); end
            prev_fill = int'(a_fill);
        end
        $display("test_backpressure: done");
    endtask

    task automatic test_reset_mid();
        logic [IW-1:0] w;
        cycle_a(1'b1, 1'b0, '0);
        cycle_a(1'b0, 1'b1, rand_word());
        cycle_a(1'b0, 1'b1, rand_word());
        total++; if (a_fill !== 7'd47) begin bad++; $display("FAIL mid_prefill: got %0d want 47", a_fill); end
        cycle_a(1'b1, 1'b1, rand_word());
        total++; if (a_fill !== 7'd0) begin bad++; $display("FAIL mid_fill: got %0d want 0", a_fill); end
        total++; if (a_dout !== '0) begin bad++; $display("FAIL mid_dout: got %h want 0", a_dout); end
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", obs_ready); end
        w = rand_word();
        cycle_a(1'b0, 1'b1, w);
        cycle_a(1'b0, 1'b0, '0);
        total++; if (a_dout !== w[IW-1 -: OW] || a_valid_o !== 1'b1) begin bad++; $display("FAIL mid_first_slice: got %h/%b want %h/1", a_dout, a_valid_o, w[IW-1 -: OW]); end
        total++; if (a_fill !== 7'd47) begin bad++; $display("FAIL mid_after_fill: got %0d want 47", a_fill); end
        $display("test_reset_mid: done");
    endtask

    task automatic test_alt_params();
        @(negedge clk); b_rst = 1'b1; b_vld = 1'b0;
        @(negedge clk); b_rst = 1'b0; b_din = 67'h0_00000000_FFFFFFFF; b_vld = 1'b1;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL alt_ready: got %b want 1", b_ready); end
        @(negedge clk); b_vld = 1'b0;
        total++; if (b_fill !== 7'd67 || b_valid_o !== 1'b0) begin bad++; $display("FAIL alt_accept: got fill=%0d v=%b want 67/0", b_fill, b_valid_o); end
        @(negedge clk);
        total++; if (b_dout !== 32'hFFFFFFFF || b_valid_o !== 1'b1) begin bad++; $display("FAIL alt_slice0: got %h/%b want ffffffff/1", b_dout, b_valid_o); end
        @(negedge clk);
        total++; if (b_dout !== 32'h00000000 || b_valid_o !== 1'b1) begin bad++; $display("FAIL alt_slice1: got %h/%b want 00000000/1", b_dout, b_valid_o); end
        total++; if (b_fill !== 7'd3) begin bad++; $display("FAIL alt_fill: got %0d want 3", b_fill); end
        @(negedge clk);
        total++; if (b_valid_o !== 1'b0 || b_under !== 1'b1) begin bad++; $display("FAIL alt_idle: got v=%b u=%b want 0/1", b_valid_o, b_under); end
        $display("test_alt_params: done");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_saturated();
        test_backpressure();
        test_reset_mid();
        test_alt_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
